hangman_game_ctrl: RTL and testbench

Central game sequencer for wireless hangman; sits between the keypad character decoder and the UART/LCD datapath in main. Captures the host's secret word, streams it out over the byte-wide tx handshake, then scores player guesses (hit mask, mistake count) and drives RGB/error/msg_sent status. One instance per board; role_switch selects the host or player phase.

---
 rtl/hangman_pkg.sv | 25 ++
 rtl/word_matcher.sv | 18 +
 rtl/hangman_game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hangman_game_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game sequencer.
package hangman_pkg;

    localparam int unsigned WORD_LEN_DEF     = 5;
    localparam int unsigned MAX_MISTAKES_DEF = 6;
    localparam int unsigned CHAR_W_DEF       = 8;

    localparam logic [7:0] CHAR_A = 8'h41;
    localparam logic [7:0] CHAR_Z = 8'h5A;

    typedef enum logic [2:0] {
        SET_WORD,
        SEND,
        WAIT_PLAYER,
        GUESS,
        CHECK,
        WIN,
        LOSE
    } state_t;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= CHAR_A) && (c <= CHAR_Z);
    endfunction

endpackage

// File: rtl/word_matcher.sv
// Combinational per-position compare of a guess letter against the stored word.
module word_matcher #(
    parameter int unsigned WORD_LEN = 5,
    parameter int unsigned CHAR_W   = 8
) (
    input  logic [WORD_LEN*CHAR_W-1:0] word_flat,
    input  logic [CHAR_W-1:0]          guess,
    output logic [WORD_LEN-1:0]        match_c
);

    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(WORD_LEN); i++) begin
            match_c[i] = (word_flat[i*CHAR_W +: CHAR_W] == guess);
        end
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman sequencer: captures the host word, streams it to the UART,
// then scores player guesses and drives the status LEDs.
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN     = WORD_LEN_DEF,
    parameter int unsigned MAX_MISTAKES = MAX_MISTAKES_DEF,
    parameter int unsigned CHAR_W       = CHAR_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 nRst,
    input  logic                                 role_switch,
    input  logic [CHAR_W-1:0]                    key_char,
    input  logic                                 key_valid,
    input  logic                                 game_end,
    input  logic                                 tx_ready,
    output logic                                 tx_req,
    output logic [CHAR_W-1:0]                    tx_data,
    output logic [WORD_LEN*CHAR_W-1:0]           word_flat,
    output logic [WORD_LEN-1:0]                  guessed_mask,
    output logic [$clog2(MAX_MISTAKES+1)-1:0]    mistakes,
    output logic                                 red,
    output logic                                 green,
    output logic                                 blue,
    output logic                                 error,
    output logic                                 msg_sent
);

    localparam int unsigned IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int unsigned MIS_W = $clog2(MAX_MISTAKES + 1);

    state_t                             state;
    logic [WORD_LEN-1:0][CHAR_W-1:0]    word;
    logic [IDX_W-1:0]                   wr_idx;
    logic [IDX_W-1:0]                   tx_idx;
    logic [CHAR_W-1:0]                  guess;
    logic [CHAR_W-1:0]                  cmp_char;
    logic [WORD_LEN-1:0]                match_c;
    logic [WORD_LEN-1:0]                mask_hit;
    logic [MIS_W-1:0]                   mistakes_inc;
    logic                               key_ok;
    logic                               repeat_hit;

    assign word_flat = word;
    assign key_ok    = is_letter(8'(key_char));

    // One matcher serves both the repeat check in GUESS and the scoring in CHECK.
    assign cmp_char = (state == CHECK) ? guess : key_char;

    word_matcher #(
        .WORD_LEN (WORD_LEN),
        .CHAR_W   (CHAR_W)
    ) u_word_matcher (
        .word_flat (word),
        .guess     (cmp_char),
        .match_c   (match_c)
    );

    assign repeat_hit   = |(match_c & guessed_mask);
    assign mask_hit     = guessed_mask | match_c;
    assign mistakes_inc = (mistakes < MIS_W'(MAX_MISTAKES)) ? mistakes + MIS_W'(1) : mistakes;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= SET_WORD;
            word         <= '0;
            wr_idx       <= '0;
            tx_idx       <= '0;
            guess        <= '0;
            guessed_mask <= '0;
            mistakes     <= '0;
            tx_req       <= 1'b0;
            tx_data      <= '0;
            red          <= 1'b0;
            green        <= 1'b0;
            blue         <= 1'b0;
            error        <= 1'b0;
            msg_sent     <= 1'b0;
        end else begin
            error    <= 1'b0;
            msg_sent <= 1'b0;
            red      <= 1'b0;
            green    <= 1'b0;
            if (game_end) begin
                state        <= SET_WORD;
                word         <= '0;
                wr_idx       <= '0;
                tx_idx       <= '0;
                guess        <= '0;
                guessed_mask <= '0;
                mistakes     <= '0;
                tx_req       <= 1'b0;
                tx_data      <= '0;
                blue         <= 1'b0;
            end else begin
                case (state)
                    SET_WORD: begin
                        if (key_valid) begin
                            if (key_ok) begin
                                word[wr_idx] <= key_char;
                                if (wr_idx == IDX_W'(WORD_LEN - 1)) begin
                                    state   <= SEND;
                                    wr_idx  <= '0;
                                    tx_idx  <= '0;
                                    tx_req  <= 1'b1;
                                    tx_data <= (wr_idx == '0) ? key_char : word[0];
                                end else begin
                                    wr_idx <= wr_idx + IDX_W'(1);
                                end
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (tx_ready) begin
                            if (tx_idx == IDX_W'(WORD_LEN - 1)) begin
                                state    <= WAIT_PLAYER;
                                tx_req   <= 1'b0;
                                tx_idx   <= '0;
                                msg_sent <= 1'b1;
                                blue     <= 1'b1;
                            end else begin
                                tx_idx  <= tx_idx + IDX_W'(1);
                                tx_data <= word[tx_idx + IDX_W'(1)];
                            end
                        end
                    end
                    WAIT_PLAYER: begin
                        if (role_switch) begin
                            state <= GUESS;
                        end
                    end
                    GUESS: begin
                        if (key_valid) begin
                            if (!key_ok || repeat_hit) begin
                                error <= 1'b1;
                            end else begin
                                guess <= key_char;
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        guessed_mask <= mask_hit;
                        if (|match_c) begin
                            green <= 1'b1;
                        end else begin
                            mistakes <= mistakes_inc;
                            red      <= 1'b1;
                        end
                        if (&mask_hit) begin
                            state <= WIN;
                        end else if (!(|match_c) && (mistakes_inc == MIS_W'(MAX_MISTAKES))) begin
                            state <= LOSE;
                        end else begin
                            state <= GUESS;
                        end
                    end
                    WIN: begin
                        green <= 1'b1;
                        blue  <= 1'b0;
                    end
                    LOSE: begin
                        red          <= 1'b1;
                        blue         <= 1'b0;
                        guessed_mask <= '1;
                    end
                    default: state <= SET_WORD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Bench for hangman_game_ctrl: directed scenarios plus random play, all checked
// every cycle against a letter/array level model of the game rules.
module tb_hangman_game_ctrl;

    localparam int WL = 5;
    localparam int MM = 6;

    localparam int S_SETUP = 0;
    localparam int S_SEND  = 1;
    localparam int S_WAIT  = 2;
    localparam int S_GUESS = 3;
    localparam int S_SCORE = 4;
    localparam int S_WON   = 5;
    localparam int S_LOST  = 6;

    logic         clk;
    logic         nRst;
    logic         role_switch;
    logic [7:0]   key_char;
    logic         key_valid;
    logic         game_end;
    logic         tx_ready;
    logic         tx_req;
    logic [7:0]   tx_data;
    logic [39:0]  word_flat;
    logic [4:0]   guessed_mask;
    logic [2:0]   mistakes;
    logic         red;
    logic         green;
    logic         blue;
    logic         error;
    logic         msg_sent;

    hangman_game_ctrl dut (
        .clk          (clk),
        .nRst         (nRst),
        .role_switch  (role_switch),
        .key_char     (key_char),
        .key_valid    (key_valid),
        .game_end     (game_end),
        .tx_ready     (tx_ready),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .word_flat    (word_flat),
        .guessed_mask (guessed_mask),
        .mistakes     (mistakes),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .error        (error),
        .msg_sent     (msg_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: stored letters, revealed positions, miss count, pending events.
    int         stage;
    int         age;
    int         nstored;
    int         nsent;
    int         miss;
    logic [7:0] mw [WL];
    logic [7:0] mg;
    bit         rev [WL];
    bit         ev_err, ev_sent, ev_hit, ev_miss;
    logic [7:0] sent_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        stage = S_SETUP; nstored = 0; nsent = 0; miss = 0; mg = 8'h00;
        for (int i = 0; i < WL; i++) begin
            mw[i] = 8'h00;
            rev[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int prev;
        bit letter, dup, all_rev;
        prev = stage;
        letter = (key_char >= 8'h41) && (key_char <= 8'h5A);
        ev_err = 0; ev_sent = 0; ev_hit = 0; ev_miss = 0;
        if (game_end) begin
            model_clear();
        end else begin
            case (stage)
                S_SETUP: if (key_valid) begin
                    if (letter) begin
                        mw[nstored] = key_char;
                        nstored++;
                        if (nstored == WL) begin stage = S_SEND; nsent = 0; end
                    end else ev_err = 1;
                end
                S_SEND: if (tx_ready) begin
                    nsent++;
                    if (nsent == WL) begin stage = S_WAIT; ev_sent = 1; end
                end
                S_WAIT: if (role_switch) stage = S_GUESS;
                S_GUESS: if (key_valid) begin
                    dup = 0;
                    for (int i = 0; i < WL; i++) if (rev[i] && mw[i] == key_char) dup = 1;
                    if (!letter || dup) ev_err = 1;
                    else begin mg = key_char; stage = S_SCORE; end
                end
                S_SCORE: begin
                    all_rev = 1;
                    for (int i = 0; i < WL; i++) begin
                        if (mw[i] == mg) begin rev[i] = 1; ev_hit = 1; end
                        all_rev = all_rev & rev[i];
                    end
                    if (!ev_hit) begin
                        ev_miss = 1;
                        if (miss < MM) miss++;
                    end
                    if (all_rev) stage = S_WON;
                    else if (miss == MM) stage = S_LOST;
                    else stage = S_GUESS;
                end
                default: ;
            endcase
        end
        age = (stage == prev) ? age + 1 : 0;
    endtask

    task automatic compare_all();
        logic [39:0] ew;
        logic [4:0]  em;
        bit          settled;
        settled = (age >= 1);
        for (int i = 0; i < WL; i++) begin
            ew[i*8 +: 8] = mw[i];
            em[i] = rev[i];
        end
        if (stage == S_LOST && settled) em = 5'b11111;
        chk("tx_req", tx_req, 64'(stage == S_SEND));
        if (stage == S_SEND) chk("tx_data", tx_data, 64'(mw[nsent]));
        chk("word_flat", word_flat, 64'(ew));
        chk("guessed_mask", guessed_mask, 64'(em));
        chk("mistakes", mistakes, 64'(miss));
        chk("red", red, 64'(ev_miss || (stage == S_LOST && settled)));
        chk("green", green, 64'(ev_hit || (stage == S_WON && settled)));
        chk("blue", blue, 64'((stage == S_WAIT) || (stage == S_GUESS) || (stage == S_SCORE)
                              || (((stage == S_WON) || (stage == S_LOST)) && !settled)));
        chk("error", error, 64'(ev_err));
        chk("msg_sent", msg_sent, 64'(ev_sent));
    endtask

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            model_clear();
            age = 0;
            ev_err = 0; ev_sent = 0; ev_hit = 0; ev_miss = 0;
        end else begin
            if (tx_req && tx_ready) sent_q.push_back(tx_data);
            model_step();
        end
        #1;
        compare_all();
    end

    task automatic press(input logic [7:0] c);
        @(negedge clk);
        key_char = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic guess_letter(input logic [7:0] c);
        press(c);
        @(negedge clk);
    endtask

    task automatic pulse_end();
        @(negedge clk);
        game_end = 1'b1;
        @(negedge clk);
        game_end = 1'b0;
    endtask

    task automatic enter_apple();
        press(8'h41); press(8'h50); press(8'h50); press(8'h4C); press(8'h45);
    endtask

    task automatic wait_sent();
        bit got;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (msg_sent) got = 1;
        end
        chk("msg_sent_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        bit got;
        nRst = 1'b0; role_switch = 1'b0; key_char = 8'h00;
        key_valid = 1'b0; game_end = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx_req", tx_req, 0);
        chk("reset_word", word_flat, 0);
        chk("reset_blue", blue, 0);
        nRst = 1'b1;

        press(8'h33);
        chk("bad_key_error", error, 1);
        chk("bad_key_word", word_flat, 0);

        // Host word with a 4-cycle stall in the middle of the send.
        sent_q.delete();
        tx_ready = 1'b1;
        enter_apple();
        chk("apple_word", word_flat, 64'h45_4C_50_50_41);
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tx_ready = !(c >= 2 && c < 6);
            @(negedge clk);
            if (msg_sent) got = 1;
        end
        chk("send_done", 64'(got), 1);
        chk("sent_count", 64'(sent_q.size()), 5);
        if (sent_q.size() == 5) begin
            chk("byte0", sent_q[0], 8'h41);
            chk("byte1", sent_q[1], 8'h50);
            chk("byte2", sent_q[2], 8'h50);
            chk("byte3", sent_q[3], 8'h4C);
            chk("byte4", sent_q[4], 8'h45);
        end
        chk("wait_blue", blue, 1);
        @(negedge clk);
        chk("msg_sent_single", msg_sent, 0);

        // Player wins.
        role_switch = 1'b1;
        @(negedge clk);
        guess_letter(8'h50);
        chk("hit_p_mask", guessed_mask, 5'b00110);
        chk("hit_p_green", green, 1);
        guess_letter(8'h48);
        chk("miss_h_count", mistakes, 1);
        chk("miss_h_red", red, 1);
        press(8'h50);
        chk("repeat_p_error", error, 1);
        chk("repeat_p_mistakes", mistakes, 1);
        @(negedge clk);
        guess_letter(8'h41);
        guess_letter(8'h45);
        guess_letter(8'h4C);
        chk("win_mask", guessed_mask, 5'b11111);
        @(negedge clk);
        chk("win_green", green, 1);
        chk("win_blue", blue, 0);

        // Player loses after six distinct misses.
        pulse_end();
        chk("end_word", word_flat, 0);
        chk("end_mask", guessed_mask, 0);
        tx_ready = 1'b1;
        enter_apple();
        wait_sent();
        guess_letter(8'h42); guess_letter(8'h43); guess_letter(8'h44);
        guess_letter(8'h46); guess_letter(8'h47); guess_letter(8'h48);
        chk("lose_mistakes", mistakes, 6);
        @(negedge clk);
        chk("lose_red", red, 1);
        chk("lose_reveal", guessed_mask, 5'b11111);
        press(8'h58);
        @(negedge clk);
        chk("lose_sat", mistakes, 6);
        chk("lose_no_error", error, 0);

        // Abort in the middle of a send.
        pulse_end();
        tx_ready = 1'b0;
        enter_apple();
        chk("stall_tx_req", tx_req, 1);
        repeat (2) @(negedge clk);
        pulse_end();
        chk("abort_tx_req", tx_req, 0);
        chk("abort_word", word_flat, 0);

        // Asynchronous reset during a guess with three misses.
        tx_ready = 1'b1;
        enter_apple();
        wait_sent();
        guess_letter(8'h42); guess_letter(8'h43); guess_letter(8'h44);
        chk("pre_rst_mistakes", mistakes, 3);
        #2 nRst = 1'b0;
        #1;
        chk("async_mistakes", mistakes, 0);
        chk("async_blue", blue, 0);
        chk("async_word", word_flat, 0);
        @(negedge clk);
        nRst = 1'b1;
        role_switch = 1'b0;
        enter_apple();
        chk("post_rst_word", word_flat, 64'h45_4C_50_50_41);

        // Random play.
        pulse_end();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tx_ready  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) == 0) role_switch = ~role_switch;
            game_end  = ($urandom_range(0, 199) == 0);
            key_valid = ($urandom_range(0, 3) == 0);
            key_char  = ($urandom_range(0, 9) < 8) ? 8'(8'h41 + $urandom_range(0, 7))
                                                   : 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        key_valid = 1'b0; game_end = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
